pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the MIPS datapath: holds the program counter, exports PC and the constant 4 to the team's 32-bit ripple adder, and consumes the returned sum as PC+4. Runs a request/acknowledge fetch against instruction memory and presents each fetched word to decode with a valid/ready handshake. Applies jump and branch redirects at the decode handoff.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/pc_fetch_unit.sv | 90 +++++++++
 tb/tb_pc_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, fetches from instruction memory by req/ack and
// hands each word to decode with valid/ready, applying jump/branch redirects.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    input  logic [31:0] adder_sum,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic [31:0]  branch_target;
    logic         handoff;

    assign adder_a   = pc;
    assign adder_b   = PC_INCR;
    assign imem_addr = pc;

    assign handoff       = (state == HOLD) && instr_ready && !stall;
    assign branch_target = adder_sum + (branch_offset << 2);

    // Jump outranks branch; both are relative to the externally computed PC+4.
    always_comb begin
        next_pc = adder_sum;
        if (jump) begin
            next_pc = {adder_sum[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (handoff) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected requests and
// handoffs, a negedge monitor pops and compares them as the DUT presents them.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] KEY    = 32'h2008_0005;

    logic        CLK;
    logic        RESET;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic [31:0] adder_sum;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        jump;
    logic [25:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_offset;

    pc_fetch_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .adder_a      (adder_a),
        .adder_b      (adder_b),
        .adder_sum    (adder_sum),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset)
    );

    // Stand-in for the team's 32-bit ripple adder.
    assign adder_sum = adder_a + adder_b;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_ipc_q[$];
    logic [31:0] exp_req_q[$];
    logic [31:0] cur_pc;

    int mem_delay = 0;
    bit force_ack = 1'b0;
    int wait_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers a held request after mem_delay cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge CLK);
            #2;
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt   = 0;
            end else if (imem_req && !RESET) begin
                if (wait_cnt >= mem_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ KEY;
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: new requests and decode handoffs are checked against the queues.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_req = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL req_unexpected: got addr %h, expected no request", imem_addr);
                    end else begin
                        check("req_addr", imem_addr, exp_req_q.pop_front());
                    end
                end
                prev_req = imem_req;
                if (instr_valid && instr_ready && !stall) begin
                    if (exp_instr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL handoff_unexpected: got pc %h, expected no handoff", instr_pc);
                    end else begin
                        check("handoff_instr", instr, exp_instr_q.pop_front());
                        check("handoff_pc", instr_pc, exp_ipc_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!instr_valid && k < 20) begin
            cyc();
            k++;
        end
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    // Wait for HOLD, hand off with the given redirect, expect new request at nxt.
    task automatic handoff(input bit j, input logic [25:0] tgt, input bit br,
                           input logic [31:0] off, input logic [31:0] nxt);
        wait_valid();
        exp_instr_q.push_back(cur_pc ^ KEY);
        exp_ipc_q.push_back(cur_pc);
        exp_req_q.push_back(nxt);
        jump          = j;
        jump_target   = tgt;
        branch_taken  = br;
        branch_offset = off;
        instr_ready   = 1'b1;
        cyc();
        jump          = 1'b0;
        branch_taken  = 1'b0;
        jump_target   = 26'h155_5555;
        branch_offset = 32'h7FFF_0000;
        instr_ready   = 1'b0;
        check("next_pc", imem_addr, nxt);
        check("next_req", {31'd0, imem_req}, 32'd1);
        cur_pc = nxt;
    endtask

    initial begin
        RESET         = 1'b1;
        instr_ready   = 1'b0;
        stall         = 1'b0;
        jump          = 1'b0;
        jump_target   = 26'd0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        cyc(2);

        // Reset state
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_adder_a", adder_a, RST_PC);
        check("rst_adder_b", adder_b, 32'd4);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);

        // Peak throughput: one instruction every second cycle
        exp_req_q.push_back(32'h0040_0000);
        exp_req_q.push_back(32'h0040_0004);
        exp_req_q.push_back(32'h0040_0008);
        exp_instr_q.push_back(32'h0040_0000 ^ KEY);
        exp_ipc_q.push_back(32'h0040_0000);
        exp_instr_q.push_back(32'h0040_0004 ^ KEY);
        exp_ipc_q.push_back(32'h0040_0004);
        instr_ready = 1'b1;
        RESET       = 1'b0;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check("valid_pattern", {31'd0, instr_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i == 1) begin
                check("first_req", {31'd0, imem_req}, 32'd1);
                check("first_addr", imem_addr, RST_PC);
            end
        end
        instr_ready = 1'b0;
        cur_pc      = 32'h0040_0008;

        // Ack delayed 3 cycles: request held stable for 4 cycles
        mem_delay = 3;
        exp_instr_q.push_back(cur_pc ^ KEY);
        exp_ipc_q.push_back(cur_pc);
        exp_req_q.push_back(32'h0040_000C);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            check("slow_req", {31'd0, imem_req}, 32'd1);
            check("slow_addr", imem_addr, 32'h0040_000C);
            check("slow_valid", {31'd0, instr_valid}, 32'd0);
        end
        cyc();
        check("slow_valid_after_ack", {31'd0, instr_valid}, 32'd1);
        check("slow_instr", instr, 32'h0040_000C ^ KEY);
        mem_delay = 0;
        cur_pc    = 32'h0040_000C;

        // Stall with ready: instruction held, no new request
        stall       = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_instr_pc", instr_pc, cur_pc);
            check("stall_instr", instr, cur_pc ^ KEY);
        end
        exp_instr_q.push_back(cur_pc ^ KEY);
        exp_ipc_q.push_back(cur_pc);
        exp_req_q.push_back(32'h0040_0010);
        stall = 1'b0;
        cyc();
        instr_ready = 1'b0;
        check("unstall_addr", imem_addr, 32'h0040_0010);
        cur_pc = 32'h0040_0010;

        // Redirects and stray ack in HOLD without handoff are ignored
        wait_valid();
        jump          = 1'b1;
        jump_target   = 26'h3FF_FFFF;
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FF9C;
        force_ack     = 1'b1;
        cyc(2);
        force_ack    = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("hold_ack_instr", instr, cur_pc ^ KEY);
        check("hold_ack_pc", instr_pc, cur_pc);
        check("hold_ack_req", {31'd0, imem_req}, 32'd0);
        check("hold_ack_addr", imem_addr, cur_pc);

        handoff(1'b0, 26'd0, 1'b1, 32'hFFFF_FFFE, 32'h0040_000C);
        handoff(1'b1, 26'h10_0000, 1'b1, 32'hFFFF_FFFE, 32'h0040_0000);
        handoff(1'b1, 26'h3FF_FFFF, 1'b0, 32'd0, 32'h0FFF_FFFC);
        handoff(1'b0, 26'd0, 1'b1, 32'hFBFF_FFFF, 32'hFFFF_FFFC);
        handoff(1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_0000);
        mem_delay = 10;
        handoff(1'b0, 26'd0, 1'b0, 32'd0, 32'h0000_0004);

        // Reset during an outstanding request; acks around IDLE are ignored
        cyc(2);
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        RESET = 1'b1;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_addr", imem_addr, RST_PC);
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("async_rst_instr", instr, 32'd0);
        force_ack = 1'b1;
        exp_req_q.push_back(RST_PC);
        cyc();
        RESET = 1'b0;
        check("idle2_req", {31'd0, imem_req}, 32'd0);
        check("idle2_valid", {31'd0, instr_valid}, 32'd0);
        cyc();
        check("after_idle_valid", {31'd0, instr_valid}, 32'd0);
        check("after_idle_req", {31'd0, imem_req}, 32'd1);
        check("after_idle_addr", imem_addr, RST_PC);
        force_ack = 1'b0;
        mem_delay = 0;
        cyc();
        check("refetch_valid", {31'd0, instr_valid}, 32'd1);
        check("refetch_instr", instr, RST_PC ^ KEY);
        check("refetch_pc", instr_pc, RST_PC);
        cur_pc = RST_PC;
        handoff(1'b0, 26'd0, 1'b0, 32'd0, 32'h0040_0004);
        cyc(3);

        check("instr_q_drained", exp_instr_q.size(), 32'd0);
        check("req_q_drained", exp_req_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
